// File: rtl/mole_spawner.sv
// Whack-a-mole spawner: turns tick pulses into one-at-a-time moles, ages them and resolves hits.
module mole_spawner #(
    parameter int unsigned     N_HOLES    = 8,
    parameter int unsigned     LFSR_W     = 16,
    parameter logic [15:0]     SEED       = 16'hACE1,
    parameter int unsigned     LIFE_TICKS = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       tick,
    input  logic                       hit_valid,
    input  logic [$clog2(N_HOLES)-1:0] hit_idx,
    output logic                       mole_valid,
    output logic [$clog2(N_HOLES)-1:0] mole_idx,
    output logic [N_HOLES-1:0]         mole_onehot,
    output logic                       hit_ok,
    output logic                       hit_wrong,
    output logic                       miss,
    output logic [7:0]                 hit_count
);

    localparam int unsigned IW     = $clog2(N_HOLES);
    localparam int unsigned LIFE_W = 8;
    localparam logic [LFSR_W-1:0] LFSR_MASK = LFSR_W'(16'hB400);
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [LFSR_W-1:0] SEED_EFF  = (SEED == 16'h0000) ? LFSR_W'(1) : LFSR_W'(SEED);
    localparam logic [LIFE_W-1:0] LIFE_INIT = LIFE_W'(LIFE_TICKS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_UP   = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [IW-1:0]       prev_idx_q, prev_idx_d;
    logic [LIFE_W-1:0]   life_q, life_d;
    logic                mole_valid_q, mole_valid_d;
    logic [IW-1:0]       mole_idx_q, mole_idx_d;
    logic [N_HOLES-1:0]  mole_onehot_q, mole_onehot_d;
    logic                hit_ok_q, hit_ok_d;
    logic                hit_wrong_q, hit_wrong_d;
    logic                miss_q, miss_d;
    logic [7:0]          hit_count_q, hit_count_d;

    logic [IW-1:0]       cand_raw_c;
    logic [IW-1:0]       cand_c;
    logic                hit_match_c;

    // Spawn candidate: low LFSR bits, bumped by one if it would repeat the last hole.
    always_comb begin
        cand_raw_c  = lfsr_q[IW-1:0];
        cand_c      = (cand_raw_c == prev_idx_q) ? cand_raw_c + IW'(1) : cand_raw_c;
        hit_match_c = hit_valid && (hit_idx == mole_idx_q);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        prev_idx_d   = prev_idx_q;
        life_d       = life_q;
        mole_valid_d = mole_valid_q;
        mole_idx_d   = mole_idx_q;
        hit_ok_d     = 1'b0;
        hit_wrong_d  = 1'b0;
        miss_d       = 1'b0;
        hit_count_d  = hit_count_q;

        if (!en) begin
            state_d      = ST_IDLE;
            life_d       = '0;
            mole_valid_d = 1'b0;
        end else begin
            lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_MASK : '0);
            unique case (state_q)
                ST_IDLE: begin
                    if (hit_valid) begin
                        hit_wrong_d = 1'b1;
                    end
                    if (tick) begin
                        state_d      = ST_UP;
                        mole_valid_d = 1'b1;
                        mole_idx_d   = cand_c;
                        prev_idx_d   = cand_c;
                        life_d       = LIFE_INIT;
                    end
                end
                ST_UP: begin
                    if (hit_match_c) begin
                        // A correct hit wins over an expiring tick in the same cycle.
                        state_d      = ST_IDLE;
                        hit_ok_d     = 1'b1;
                        mole_valid_d = 1'b0;
                        life_d       = '0;
                        if (hit_count_q != 8'hFF) begin
                            hit_count_d = hit_count_q + 8'd1;
                        end
                    end else begin
                        if (hit_valid) begin
                            hit_wrong_d = 1'b1;
                        end
                        if (tick) begin
                            if (life_q > LIFE_W'(1)) begin
                                life_d = life_q - LIFE_W'(1);
                            end else begin
                                state_d      = ST_IDLE;
                                miss_d       = 1'b1;
                                mole_valid_d = 1'b0;
                                life_d       = '0;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        mole_onehot_d = mole_valid_d ? (N_HOLES'(1) << mole_idx_d) : '0;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            lfsr_q        <= SEED_EFF;
            prev_idx_q    <= '0;
            life_q        <= '0;
            mole_valid_q  <= 1'b0;
            mole_idx_q    <= '0;
            mole_onehot_q <= '0;
            hit_ok_q      <= 1'b0;
            hit_wrong_q   <= 1'b0;
            miss_q        <= 1'b0;
            hit_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            prev_idx_q    <= prev_idx_d;
            life_q        <= life_d;
            mole_valid_q  <= mole_valid_d;
            mole_idx_q    <= mole_idx_d;
            mole_onehot_q <= mole_onehot_d;
            hit_ok_q      <= hit_ok_d;
            hit_wrong_q   <= hit_wrong_d;
            miss_q        <= miss_d;
            hit_count_q   <= hit_count_d;
        end
    end

    assign mole_valid  = mole_valid_q;
    assign mole_idx    = mole_idx_q;
    assign mole_onehot = mole_onehot_q;
    assign hit_ok      = hit_ok_q;
    assign hit_wrong   = hit_wrong_q;
    assign miss        = miss_q;
    assign hit_count   = hit_count_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Bench for mole_spawner: directed scenarios plus random play against a behavioural game model.
module tb_mole_spawner;

    localparam int N    = 8;
    localparam int LIFE = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       tick = 1'b0;
    logic       hit_valid = 1'b0;
    logic [2:0] hit_idx = 3'd0;
    logic       mole_valid;
    logic [2:0] mole_idx;
    logic [7:0] mole_onehot;
    logic       hit_ok;
    logic       hit_wrong;
    logic       miss;
    logic [7:0] hit_count;

    mole_spawner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .tick       (tick),
        .hit_valid  (hit_valid),
        .hit_idx    (hit_idx),
        .mole_valid (mole_valid),
        .mole_idx   (mole_idx),
        .mole_onehot(mole_onehot),
        .hit_ok     (hit_ok),
        .hit_wrong  (hit_wrong),
        .miss       (miss),
        .hit_count  (hit_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural game model
    int unsigned m_lfsr;
    int          m_prev;
    bit          m_up;
    int          m_idx;
    int          m_life;
    int          m_count;
    bit          m_ok, m_wrong, m_miss;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int next_spot(input int unsigned l, input int prev);
        int c;
        c = int'(l % 8);
        if (c == prev) c = (c + 1) % N;
        return c;
    endfunction

    task automatic model_reset();
        m_lfsr = 32'hACE1; m_prev = 0; m_up = 0; m_idx = 0; m_life = 0; m_count = 0;
        m_ok = 0; m_wrong = 0; m_miss = 0;
    endtask

    task automatic model_step(input bit r, input bit e, input bit t, input bit hv, input int hi);
        int c;
        if (!r) begin
            model_reset();
            return;
        end
        m_ok = 0; m_wrong = 0; m_miss = 0;
        if (!e) begin
            m_up = 0; m_life = 0;
            return;
        end
        c = next_spot(m_lfsr, m_prev);
        if (!m_up) begin
            if (hv) m_wrong = 1;
            if (t) begin m_up = 1; m_idx = c; m_prev = c; m_life = LIFE; end
        end else if (hv && hi == m_idx) begin
            m_ok = 1; m_up = 0; m_life = 0;
            if (m_count < 255) m_count++;
        end else begin
            if (hv) m_wrong = 1;
            if (t) begin
                if (m_life > 1) m_life--;
                else begin m_miss = 1; m_up = 0; m_life = 0; end
            end
        end
        m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 32'hB400 : 32'h0);
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".mole_valid"}, 32'(mole_valid), 32'(m_up));
        chk({tag, ".mole_idx"},   32'(mole_idx),   m_idx);
        chk({tag, ".onehot"},     32'(mole_onehot), m_up ? (1 << m_idx) : 0);
        chk({tag, ".hit_ok"},     32'(hit_ok),     32'(m_ok));
        chk({tag, ".hit_wrong"},  32'(hit_wrong),  32'(m_wrong));
        chk({tag, ".miss"},       32'(miss),       32'(m_miss));
        chk({tag, ".hit_count"},  32'(hit_count),  m_count);
    endtask

    // One clock: drive inputs, advance the model across the edge, compare #1 after.
    task automatic step(input string tag, input bit r, input bit e, input bit t,
                        input bit hv, input int hi);
        rst_n = r; en = e; tick = t; hit_valid = hv; hit_idx = 3'(hi);
        @(posedge clk);
        model_step(r, e, t, hv, hi);
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1, 1, 0, 0, 0);
    endtask

    int  exp_idx;
    int  k;
    bit  found;
    int  spawns;
    int  last_spawn;
    bit  prev_obs_valid;
    int  budget;

    initial begin
        model_reset();

        // 0: reset state
        step("reset", 0, 0, 0, 0, 0);
        step("reset2", 0, 1, 1, 1, 3);

        // 1: tick at cycle 5 after reset spawns at cycle 6
        idle("t1_idle", 4);
        exp_idx = next_spot(m_lfsr, m_prev);
        step("t1_tick", 1, 1, 1, 0, 0);
        chk("t1_spawn_valid", 32'(mole_valid), 1);
        chk("t1_spawn_idx", 32'(mole_idx), exp_idx);

        // 2: three ticks without a hit -> miss
        for (int i = 0; i < LIFE; i++) begin
            idle("t2_gap", 2);
            step("t2_age", 1, 1, 1, 0, 0);
        end
        chk("t2_miss", 32'(miss), 1);
        chk("t2_count", 32'(hit_count), 0);
        idle("t2_after", 1);

        // 3: wrong hole keeps mole up, correct hole scores
        step("t3_spawn", 1, 1, 1, 0, 0);
        k = m_idx;
        step("t3_wrong", 1, 1, 0, 1, (k + 1) % N);
        chk("t3_wrong_pulse", 32'(hit_wrong), 1);
        chk("t3_still_up", 32'(mole_valid), 1);
        step("t3_hit", 1, 1, 0, 1, k);
        chk("t3_hit_ok", 32'(hit_ok), 1);
        chk("t3_count1", 32'(hit_count), 1);
        step("t3_idle_press", 1, 1, 0, 1, 2);
        chk("t3_idle_wrong", 32'(hit_wrong), 1);

        // 4: correct hit coincides with the expiring tick; tick while clearing does not respawn
        step("t4_spawn", 1, 1, 1, 0, 0);
        step("t4_age1", 1, 1, 1, 0, 0);
        step("t4_age2", 1, 1, 1, 1, (m_idx + 3) % N);
        step("t4_race", 1, 1, 1, 1, m_idx);
        chk("t4_race_ok", 32'(hit_ok), 1);
        chk("t4_race_miss", 32'(miss), 0);
        chk("t4_no_respawn", 32'(mole_valid), 0);
        for (int i = 0; i < 300; i++) begin
            step("t4_sat_spawn", 1, 1, 1, 0, 0);
            step("t4_sat_hit", 1, 1, 0, 1, m_idx);
        end
        chk("t4_saturated", 32'(hit_count), 255);

        // 5: candidate equal to prev_idx=7 wraps to 0
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (next_spot(m_lfsr, m_prev) == 7) begin
                step("t5_spawn7", 1, 1, 1, 0, 0);
                found = 1;
            end else begin
                idle("t5_seek7", 1);
            end
        end
        chk("t5_found7", 32'(found), 1);
        step("t5_clear", 1, 1, 0, 1, m_idx);
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            if ((m_lfsr % 8) == 7 && m_prev == 7) begin
                step("t5_wrap", 1, 1, 1, 0, 0);
                chk("t5_wrap_idx", 32'(mole_idx), 0);
                found = 1;
            end else begin
                idle("t5_seekwrap", 1);
            end
        end
        chk("t5_found_wrap", 32'(found), 1);
        step("t5_clear2", 1, 1, 0, 1, m_idx);

        // 5b: random play, consecutive spawns never repeat a hole
        spawns = 0; last_spawn = -1; prev_obs_valid = mole_valid; budget = 30000;
        while (spawns < 1000 && budget > 0) begin
            bit t, hv, e;
            int hi;
            budget--;
            e  = ($urandom_range(0, 49) != 0);
            t  = ($urandom_range(0, 2) == 0);
            hv = ($urandom_range(0, 3) == 0);
            hi = ($urandom_range(0, 1) == 0) ? m_idx : int'($urandom_range(0, N - 1));
            step("rand", 1, e, t, hv, hi);
            if (mole_valid && !prev_obs_valid) begin
                if (last_spawn >= 0) begin
                    checks++;
                    assert (32'(mole_idx) != last_spawn) else begin
                        failures++;
                        $error("FAIL rand_repeat observed=%0d expected!=%0d", mole_idx, last_spawn);
                    end
                end
                last_spawn = 32'(mole_idx);
                spawns++;
            end
            prev_obs_valid = mole_valid;
        end
        chk("rand_spawns_reached", 32'(spawns >= 1000), 1);

        // 6: en drop and mid-operation reset while UP
        idle("t6_pre", 1);
        if (!m_up) step("t6_spawn", 1, 1, 1, 0, 0);
        step("t6_en_off", 1, 0, 1, 1, m_idx);
        chk("t6_en_off_valid", 32'(mole_valid), 0);
        chk("t6_en_off_ok", 32'(hit_ok), 0);
        step("t6_en_off2", 1, 0, 1, 1, 0);
        step("t6_resume", 1, 1, 1, 0, 0);
        chk("t6_resume_spawn", 32'(mole_valid), 1);
        step("t6_rst", 0, 1, 1, 1, m_idx);
        chk("t6_rst_valid", 32'(mole_valid), 0);
        chk("t6_rst_count", 32'(hit_count), 0);
        chk("t6_rst_pulses", 32'(hit_ok | hit_wrong | miss), 0);
        idle("t6_post", 4);
        exp_idx = next_spot(32'hACE1 >> 0, 0);
        step("t6_seed_spawn", 1, 1, 1, 0, 0);
        chk("t6_spawn_after_rst", 32'(mole_idx), m_idx);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
